// File: rtl/instr_pkg.sv
// Shared instruction-format definitions: opcode map, class codes and the field packer.
// The controller imports the same package so that encode and decode agree.
package instr_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   typedef enum logic [1:0] {
      CLS_R   = 2'b00,
      CLS_LW  = 2'b01,
      CLS_SW  = 2'b10,
      CLS_BEQ = 2'b11
   } instr_class_e;

   function automatic logic [31:0] encode(
      input instr_class_e cls,
      input logic [4:0]   rs,
      input logic [4:0]   rt,
      input logic [4:0]   rd,
      input logic [4:0]   shamt,
      input logic [5:0]   funct,
      input logic [15:0]  imm
   );
      logic [31:0] word;
      case (cls)
         CLS_R:   word = {OP_RTYPE, rs, rt, rd, shamt, funct};
         CLS_LW:  word = {OP_LW,  rs, rt, imm};
         CLS_SW:  word = {OP_SW,  rs, rt, imm};
         CLS_BEQ: word = {OP_BEQ, rs, rt, imm};
         default: word = 32'h0000_0000;
      endcase
      return word;
   endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding encoded words; power-of-two depth so pointers wrap naturally.
// Asynchronous active-low reset, synchronous clear.
module instr_fifo
   import instr_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;

   // Storage, pointers and occupancy; the caller never pushes when full or pops when empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (clr) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push) begin
            mem_r[wr_ptr_r] <= wr_data;
            wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign rd_data = mem_r[rd_ptr_r];
   assign count   = count_r;

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder/loader: packs decoded fields into MIPS words, buffers them,
// and streams them to IMEM at an auto-incrementing, wrap-tracking word address.
module instr_encoder
   import instr_pkg::*;
#(
   parameter int ADDR_W     = 6,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic                          Clear,
   input  logic                          InValid,
   output logic                          InReady,
   input  logic [1:0]                    InClass,
   input  logic [4:0]                    InRs,
   input  logic [4:0]                    InRt,
   input  logic [4:0]                    InRd,
   input  logic [4:0]                    InShamt,
   input  logic [5:0]                    InFunct,
   input  logic [15:0]                   InImm,
   output logic                          MemWrite,
   input  logic                          MemReady,
   output logic [ADDR_W-1:0]             MemAddr,
   output logic [31:0]                   MemData,
   output logic [$clog2(FIFO_DEPTH):0]   Count,
   output logic                          Wrapped
);

   localparam int               CNT_W    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] ADDR_TOP = {ADDR_W{1'b1}};

   logic [31:0]       enc_s;
   logic              push_s;
   logic              pop_s;
   logic [ADDR_W-1:0] addr_r;
   logic              wrapped_r;

   // Encoding and handshake; InReady is gated by Rst so it reads 0 throughout reset.
   always_comb begin
      enc_s    = encode(instr_class_e'(InClass), InRs, InRt, InRd, InShamt, InFunct, InImm);
      InReady  = Rst && (Count < DEPTH_C);
      MemWrite = (Count != {CNT_W{1'b0}});
      push_s   = InValid && InReady;
      pop_s    = MemWrite && MemReady;
   end

   instr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk     (Clk),
      .rst_n   (Rst),
      .clr     (Clear),
      .push    (push_s),
      .wr_data (enc_s),
      .pop     (pop_s),
      .rd_data (MemData),
      .count   (Count)
   );

   // Write address advances on each accepted write; Wrapped latches the top-to-zero rollover.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         addr_r    <= {ADDR_W{1'b0}};
         wrapped_r <= 1'b0;
      end else if (Clear) begin
         addr_r    <= {ADDR_W{1'b0}};
         wrapped_r <= 1'b0;
      end else if (pop_s) begin
         addr_r <= addr_r + ADDR_W'(1);
         if (addr_r == ADDR_TOP) begin
            wrapped_r <= 1'b1;
         end
      end
   end

   assign MemAddr = addr_r;
   assign Wrapped = wrapped_r;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (ADDR_W=6, FIFO_DEPTH=4).
module tb_instr_encoder;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Clear;
   logic        InValid;
   logic        InReady;
   logic [1:0]  InClass;
   logic [4:0]  InRs, InRt, InRd, InShamt;
   logic [5:0]  InFunct;
   logic [15:0] InImm;
   logic        MemWrite;
   logic        MemReady;
   logic [5:0]  MemAddr;
   logic [31:0] MemData;
   logic [2:0]  Count;
   logic        Wrapped;

   int compared   = 0;
   int mismatched = 0;

   instr_encoder #(.ADDR_W(6), .FIFO_DEPTH(4)) dut (
      .Clk(Clk), .Rst(Rst), .Clear(Clear),
      .InValid(InValid), .InReady(InReady), .InClass(InClass),
      .InRs(InRs), .InRt(InRt), .InRd(InRd), .InShamt(InShamt),
      .InFunct(InFunct), .InImm(InImm),
      .MemWrite(MemWrite), .MemReady(MemReady), .MemAddr(MemAddr),
      .MemData(MemData), .Count(Count), .Wrapped(Wrapped)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic fields(input logic [1:0] cls, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                         input logic [15:0] imm);
      InClass = cls; InRs = rs; InRt = rt; InRd = rd;
      InShamt = sh; InFunct = fn; InImm = imm;
   endtask

   initial begin
      Rst = 1'b0; Clear = 1'b0; InValid = 1'b0; MemReady = 1'b0;
      fields(2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000);
      #3;
      chk("rst_count",    32'(Count),    32'd0);
      chk("rst_memwrite", 32'(MemWrite), 32'd0);
      chk("rst_memdata",  MemData,       32'h0000_0000);
      chk("rst_inready",  32'(InReady),  32'd0);
      chk("rst_addr",     32'(MemAddr),  32'd0);
      chk("rst_wrapped",  32'(Wrapped),  32'd0);
      #9;
      Rst = 1'b1;
      #1;
      chk("rel_inready",  32'(InReady),  32'd1);
      chk("rel_memwrite", 32'(MemWrite), 32'd0);

      // R-type add r3, r1, r2
      MemReady = 1'b1;
      fields(2'b00, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 16'h1234);
      InValid = 1'b1;
      step();
      InValid = 1'b0;
      chk("add_memwrite", 32'(MemWrite), 32'd1);
      chk("add_addr",     32'(MemAddr),  32'd0);
      chk("add_data",     MemData,       32'h0022_1820);
      chk("add_count",    32'(Count),    32'd1);
      step();
      chk("add_addr_after",  32'(MemAddr), 32'd1);
      chk("add_count_after", 32'(Count),   32'd0);

      // Clear back to address 0, then lw/sw back to back
      Clear = 1'b1;
      step();
      Clear = 1'b0;
      chk("clr_addr", 32'(MemAddr), 32'd0);
      fields(2'b01, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004);
      InValid = 1'b1;
      step();
      fields(2'b10, 5'd0, 5'd5, 5'd0, 5'd0, 6'd0, 16'h0008);
      chk("lw_data", MemData, 32'h8FA8_0004);
      chk("lw_addr", 32'(MemAddr), 32'd0);
      step();
      InValid = 1'b0;
      chk("sw_data",  MemData, 32'hAC05_0008);
      chk("sw_addr",  32'(MemAddr), 32'd1);
      chk("sw_count", 32'(Count), 32'd1);
      step();
      chk("lwsw_count", 32'(Count), 32'd0);
      chk("lwsw_addr",  32'(MemAddr), 32'd2);

      // Backpressure: five push attempts with IMEM stalled
      MemReady = 1'b0;
      InValid  = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         fields(2'b00, 5'd0, 5'd0, 5'(i), 5'd0, 6'd0, 16'h0000);
         step();
      end
      InValid = 1'b0;
      chk("full_count",   32'(Count),    32'd4);
      chk("full_inready", 32'(InReady),  32'd0);
      chk("full_write",   32'(MemWrite), 32'd1);
      chk("full_data",    MemData,       32'h0000_0800);
      step();
      chk("stall_data", MemData, 32'h0000_0800);
      chk("stall_addr", 32'(MemAddr), 32'd2);
      MemReady = 1'b1;
      step();
      chk("drain1_data",    MemData,      32'h0000_1000);
      chk("drain1_addr",    32'(MemAddr), 32'd3);
      chk("drain1_inready", 32'(InReady), 32'd1);
      chk("drain1_count",   32'(Count),   32'd3);
      step();
      chk("drain2_data", MemData, 32'h0000_1800);
      step();
      chk("drain3_data", MemData, 32'h0000_2000);
      chk("drain3_addr", 32'(MemAddr), 32'd5);
      step();
      chk("drained_count", 32'(Count), 32'd0);
      chk("drained_addr",  32'(MemAddr), 32'd6);

      // Stream 57 words to reach address 63
      fields(2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0000);
      InValid = 1'b1;
      for (int i = 0; i < 57; i++) begin
         step();
      end
      InValid = 1'b0;
      chk("stream_count", 32'(Count), 32'd1);
      step();
      chk("stream_addr", 32'(MemAddr), 32'd63);
      fields(2'b11, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF);
      InValid = 1'b1;
      step();
      InValid = 1'b0;
      chk("beq_data",    MemData,      32'h1022_FFFF);
      chk("beq_addr",    32'(MemAddr), 32'd63);
      chk("beq_wrapped", 32'(Wrapped), 32'd0);
      step();
      chk("wrap_addr",    32'(MemAddr), 32'd0);
      chk("wrap_wrapped", 32'(Wrapped), 32'd1);
      InValid = 1'b1;
      step();
      InValid = 1'b0;
      step();
      chk("sticky_addr",    32'(MemAddr), 32'd1);
      chk("sticky_wrapped", 32'(Wrapped), 32'd1);

      // Clear with three buffered words and a simultaneous push
      MemReady = 1'b0;
      InValid  = 1'b1;
      step(); step(); step();
      chk("pre_clr_count", 32'(Count), 32'd3);
      Clear = 1'b1;
      step();
      Clear = 1'b0;
      InValid = 1'b0;
      chk("clr_count",   32'(Count),    32'd0);
      chk("clr_addr2",   32'(MemAddr),  32'd0);
      chk("clr_wrapped", 32'(Wrapped),  32'd0);
      chk("clr_write",   32'(MemWrite), 32'd0);

      // Reset mid-stream at Count=2, MemAddr=10
      MemReady = 1'b1;
      InValid  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
      end
      InValid = 1'b0;
      step();
      MemReady = 1'b0;
      InValid  = 1'b1;
      fields(2'b01, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0010);
      step(); step();
      InValid = 1'b0;
      chk("mid_count", 32'(Count),   32'd2);
      chk("mid_addr",  32'(MemAddr), 32'd10);
      #2;
      Rst = 1'b0;
      #1;
      chk("async_count",   32'(Count),    32'd0);
      chk("async_addr",    32'(MemAddr),  32'd0);
      chk("async_write",   32'(MemWrite), 32'd0);
      chk("async_data",    MemData,       32'h0000_0000);
      chk("async_inready", 32'(InReady),  32'd0);
      #2;
      Rst = 1'b1;
      MemReady = 1'b1;
      fields(2'b10, 5'd2, 5'd6, 5'd0, 5'd0, 6'd0, 16'h00F0);
      InValid = 1'b1;
      step();
      InValid = 1'b0;
      chk("post_rst_addr", 32'(MemAddr), 32'd0);
      chk("post_rst_data", MemData,      32'hAC46_00F0);
      step();
      chk("post_rst_next", 32'(MemAddr), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
